// File: rtl/cam_pixel_fifo.sv
// cam_pixel_fifo: single-clock pixel FIFO for the camera path.
// Each word carries a frame-start marker in the top bit above an RGB565 pixel.
// Read data is registered (one-cycle latency). Occupancy, empty and full are
// registered and change on the same edge that moves the data.

module cam_pixel_fifo #(
   parameter int DATA_WIDTH = 17,
   parameter int DEPTH      = 1024
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_WIDTH-1:0]    data,
   input  logic                     wr_en,
   input  logic                     rd_en,
   output logic [DATA_WIDTH-1:0]    q,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]           count_q,  count_d;
   logic                  empty_q,  empty_d;
   logic                  full_q,   full_d;
   logic [DATA_WIDTH-1:0] q_q,      q_d;

   logic                  wr_ok;
   logic                  rd_ok;

   // A write while full or a read while empty is dropped. This also gives the
   // "write only" result for wr+rd while empty and "read only" while full.
   assign wr_ok = wr_en && !full_q;
   assign rd_ok = rd_en && !empty_q;

   // Next-state: pointers, occupancy, flags and read data.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      q_d      = q_q;

      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end

      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         q_d      = mem[rd_ptr_q];
      end

      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase

      empty_d = (count_d == '0);
      full_d  = (count_d == FULL_CNT);
   end

   // Control registers. Reset takes priority over any request in that cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         q_q      <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         q_q      <= q_d;
      end
   end

   // Storage array; contents are not cleared, stale words become unreachable
   // once the pointers are reset.
   always_ff @(posedge clk) begin
      if (!reset && wr_ok) begin
         mem[wr_ptr_q] <= data;
      end
   end

   assign q     = q_q;
   assign empty = empty_q;
   assign full  = full_q;
   assign count = count_q;

endmodule

// File: tb/tb_cam_pixel_fifo.sv
// tb_cam_pixel_fifo: directed bench for cam_pixel_fifo with default parameters.

module tb_cam_pixel_fifo;

   localparam int DW    = 17;
   localparam int DEPTH = 1024;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] data;
   logic          wr_en;
   logic          rd_en;
   logic [DW-1:0] q;
   logic          empty;
   logic          full;
   logic [CW-1:0] count;

   int n_assert = 0;
   int n_fail   = 0;

   logic [DW-1:0] frame_buf [392];
   logic [DW-1:0] last_q;

   cam_pixel_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .data  (data),
      .wr_en (wr_en),
      .rd_en (rd_en),
      .q     (q),
      .empty (empty),
      .full  (full),
      .count (count)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [DW-1:0] d);
      data  = d;
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rd();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   function automatic logic [DW-1:0] fill_word(input int i);
      return DW'(i * 37 + 11);
   endfunction

   function automatic logic [DW-1:0] wrap_word(input int i);
      return DW'(i * 91 + 3) ^ 17'h1_2345;
   endfunction

   initial begin
      reset = 1'b1;
      data  = '0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Reset then idle
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full",  32'(full),  32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_q",     32'(q),     32'h0);

      // 23x17 frame: marker word then 391 pixels
      frame_buf[0] = 17'h1_0000;
      for (int i = 1; i < 392; i++) frame_buf[i] = {1'b0, 16'($urandom)};
      for (int i = 0; i < 392; i++) begin
         wr(frame_buf[i]);
         chk("frame_wr_full", 32'(full), 32'd0);
      end
      chk("frame_count", 32'(count), 32'd392);
      chk("frame_empty0", 32'(empty), 32'd0);
      for (int i = 0; i < 392; i++) begin
         rd();
         chk("frame_q", 32'(q), 32'(frame_buf[i]));
         chk("frame_marker", 32'(q[16]), (i == 0) ? 32'd1 : 32'd0);
      end
      chk("frame_empty1", 32'(empty), 32'd1);
      chk("frame_count0", 32'(count), 32'd0);

      // Fill to DEPTH, drop an extra write, drain
      for (int i = 0; i < DEPTH; i++) begin
         wr(fill_word(i));
         if (i == DEPTH - 2) chk("fill_notfull", 32'(full), 32'd0);
      end
      chk("fill_full",  32'(full),  32'd1);
      chk("fill_count", 32'(count), 32'(DEPTH));
      wr(17'h1_ABCD);
      chk("drop_full",  32'(full),  32'd1);
      chk("drop_count", 32'(count), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) begin
         rd();
         chk("fill_q", 32'(q), 32'(fill_word(i)));
         if (i == 0) chk("fill_full_after_rd", 32'(full), 32'd0);
      end
      chk("fill_empty", 32'(empty), 32'd1);

      // Occupancy held at 3 through repeated wrap-around
      for (int i = 0; i < 3; i++) wr(wrap_word(i));
      chk("wrap_pre_count", 32'(count), 32'd3);
      for (int k = 0; k < 3 * DEPTH + 5; k++) begin
         data  = wrap_word(k + 3);
         wr_en = 1'b1;
         rd_en = 1'b1;
         tick();
         chk("wrap_q", 32'(q), 32'(wrap_word(k)));
         chk("wrap_count", 32'(count), 32'd3);
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
      for (int k = 3 * DEPTH + 5; k < 3 * DEPTH + 8; k++) begin
         rd();
         chk("wrap_drain_q", 32'(q), 32'(wrap_word(k)));
      end
      chk("wrap_empty", 32'(empty), 32'd1);
      last_q = wrap_word(3 * DEPTH + 7);

      // rd_en while empty leaves q alone
      rd();
      chk("rdempty_q",     32'(q),     32'(last_q));
      chk("rdempty_count", 32'(count), 32'd0);
      chk("rdempty_empty", 32'(empty), 32'd1);

      // wr+rd while empty: only the write happens
      data  = 17'h0_5555;
      wr_en = 1'b1;
      rd_en = 1'b1;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
      chk("wrrd_empty_count", 32'(count), 32'd1);
      chk("wrrd_empty_q",     32'(q),     32'(last_q));
      chk("wrrd_empty_empty", 32'(empty), 32'd0);

      // wr+rd while full: only the read happens
      for (int i = 1; i < DEPTH; i++) wr(fill_word(i));
      chk("wrrd_full_pre", 32'(full), 32'd1);
      data  = 17'h1_FFFF;
      wr_en = 1'b1;
      rd_en = 1'b1;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
      chk("wrrd_full_count", 32'(count), 32'(DEPTH - 1));
      chk("wrrd_full_full",  32'(full),  32'd0);
      chk("wrrd_full_q",     32'(q),     32'h0_5555);
      for (int i = 1; i < DEPTH; i++) begin
         rd();
         chk("wrrd_full_drain_q", 32'(q), 32'(fill_word(i)));
      end
      chk("wrrd_full_empty", 32'(empty), 32'd1);

      // Mid-operation reset discards contents; requests in the reset cycle ignored
      for (int i = 0; i < 5; i++) wr(17'h0_1000 + DW'(i));
      chk("mid_count5", 32'(count), 32'd5);
      reset = 1'b1;
      data  = 17'h1_DEAD;
      wr_en = 1'b1;
      rd_en = 1'b1;
      tick();
      reset = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_empty", 32'(empty), 32'd1);
      chk("mid_rst_full",  32'(full),  32'd0);
      chk("mid_rst_q",     32'(q),     32'h0);
      wr(17'h0_BEEF);
      chk("mid_count1", 32'(count), 32'd1);
      rd();
      chk("mid_q", 32'(q), 32'h0_BEEF);
      chk("mid_empty", 32'(empty), 32'd1);
      rd();
      chk("mid_q_hold", 32'(q), 32'h0_BEEF);
      chk("mid_count0", 32'(count), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
